// File: rtl/vector_deconcatenation_rx.sv
// vector_deconcatenation_rx
// Receive side of the packed-field byte stream. Bytes arrive MSB-first and are
// gathered into one word. The trailing marker is checked, and the word is then
// split into NUM_FIELDS fields of FIELD_W bits each. Field 0 sits in the MSBs.
// Optional feature macro: MARKER_CHECK_EN. When it is defined, a word whose
// marker does not match is dropped and counted as an error. When it is
// undefined, the marker bits are ignored and marker_err/err_cnt stay at 0.
module vector_deconcatenation_rx #(
  parameter int                  FIELD_W    = 5,
  parameter int                  NUM_FIELDS = 6,
  parameter int                  MARKER_W   = 2,
  parameter logic [MARKER_W-1:0] MARKER     = 2'b11
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sync_clr,
  input  logic [7:0]                    in_byte,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [NUM_FIELDS*FIELD_W-1:0] fields,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          marker_err,
  output logic [7:0]                    err_cnt
);

  localparam int FLD_BITS  = FIELD_W * NUM_FIELDS;
  localparam int W         = FLD_BITS + MARKER_W;
  localparam int NUM_BYTES = W / 8;
  localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);

  logic [CNT_W-1:0]    r_byte_cnt;
  logic [W-9:0]        r_shift;
  logic [FLD_BITS-1:0] r_fields;
  logic                r_out_valid;
  logic                r_marker_err;
  logic [7:0]          r_err_cnt;

  logic                w_last;
  logic                w_in_fire;
  logic                w_last_fire;
  logic [W-1:0]        w_word;
  logic                w_marker_ok;
  logic                w_good_word;
  logic                w_bad_word;

  // The last byte may only enter when the output slot is free or being emptied.
  assign w_last    = (r_byte_cnt == LAST_CNT);
  assign in_ready  = ~w_last | ~r_out_valid | out_ready;

  // A sync clear wins over the handshake, so a byte offered in that cycle is lost.
  assign w_in_fire   = in_valid & in_ready & ~sync_clr;
  assign w_last_fire = w_in_fire & w_last;

  // On the last byte this is the full assembled word. On earlier bytes it is the next shift value.
  assign w_word = {r_shift, in_byte};

`ifdef MARKER_CHECK_EN
  assign w_marker_ok = (w_word[MARKER_W-1:0] == MARKER);
`else
  logic w_unused_marker;
  assign w_marker_ok     = 1'b1;
  assign w_unused_marker = ^{w_word[MARKER_W-1:0], MARKER};
`endif

  assign w_good_word = w_last_fire & w_marker_ok;
  assign w_bad_word  = w_last_fire & ~w_marker_ok;

  // Byte alignment counter and shift register that collect the incoming word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_cnt <= '0;
      r_shift    <= '0;
    end else if (sync_clr) begin
      r_byte_cnt <= '0;
    end else if (w_in_fire) begin
      r_shift    <= w_word[W-9:0];
      r_byte_cnt <= w_last ? '0 : r_byte_cnt + CNT_W'(1);
    end
  end

  // Output slot: load a new word, hold it while stalled, or clear valid once consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fields    <= '0;
      r_out_valid <= 1'b0;
    end else if (w_good_word) begin
      r_fields    <= w_word[W-1:MARKER_W];
      r_out_valid <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Marker error pulse and saturating error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_marker_err <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_marker_err <= w_bad_word;
      if (w_bad_word && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign fields     = r_fields;
  assign out_valid  = r_out_valid;
  assign marker_err = r_marker_err;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_vector_deconcatenation_rx.sv
// Directed bench for vector_deconcatenation_rx. Expectations follow the
// MARKER_CHECK_EN setting of the build.
module tb_vector_deconcatenation_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sync_clr;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [29:0] fields;
  logic        out_valid;
  logic        out_ready;
  logic        marker_err;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;

  localparam logic [29:0] GOOD  = {5'h1F, 5'h00, 5'h15, 5'h0A, 5'h03, 5'h11};
  localparam logic [29:0] ALL1F = {6{5'h1F}};

  vector_deconcatenation_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sync_clr   (sync_clr),
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .fields     (fields),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .marker_err (marker_err),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offer one byte and wait (bounded) until it is taken.
  task automatic send_byte(input logic [7:0] b);
    int n;
    in_byte  = b;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  initial begin
    rst_n     = 1'b0;
    sync_clr  = 1'b0;
    in_byte   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_fields",     {2'b0, fields},          32'd0);
    chk("rst_out_valid",  {31'd0, out_valid},      32'd0);
    chk("rst_marker_err", {31'd0, marker_err},     32'd0);
    chk("rst_err_cnt",    {24'd0, err_cnt},        32'd0);
    chk("rst_in_ready",   {31'd0, in_ready},       32'd1);
    rst_n = 1'b1;
    tick();

    // Good word, one cycle latency, consumed the next cycle
    send_byte(8'hF8);
    send_byte(8'h2A);
    send_byte(8'hA1);
    chk("good_not_early", {31'd0, out_valid}, 32'd0);
    send_byte(8'hC7);
    chk("good_valid",      {31'd0, out_valid},  32'd1);
    chk("good_fields",     {2'b0, fields},      {2'b0, GOOD});
    chk("good_marker_err", {31'd0, marker_err}, 32'd0);
    tick();
    chk("good_consumed",   {31'd0, out_valid},  32'd0);
    chk("good_fields_kept",{2'b0, fields},      {2'b0, GOOD});

    // Bad marker
    send_word(32'hFFFFFFFC);
`ifdef MARKER_CHECK_EN
    chk("bad_marker_err", {31'd0, marker_err}, 32'd1);
    chk("bad_out_valid",  {31'd0, out_valid},  32'd0);
    chk("bad_fields",     {2'b0, fields},      {2'b0, GOOD});
    chk("bad_err_cnt",    {24'd0, err_cnt},    32'd1);
    tick();
    chk("bad_pulse_end",  {31'd0, marker_err}, 32'd0);
    chk("bad_err_cnt2",   {24'd0, err_cnt},    32'd1);
`else
    chk("nochk_out_valid", {31'd0, out_valid},  32'd1);
    chk("nochk_fields",    {2'b0, fields},      {2'b0, ALL1F});
    chk("nochk_marker",    {31'd0, marker_err}, 32'd0);
    chk("nochk_err_cnt",   {24'd0, err_cnt},    32'd0);
    tick();
`endif

    // Backpressure: held word stalls the 4th byte of the next word
    out_ready = 1'b0;
    send_word(32'hF82AA1C7);
    chk("bp_valid",  {31'd0, out_valid}, 32'd1);
    chk("bp_fields", {2'b0, fields},     {2'b0, GOOD});
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_byte(8'hFF);
    in_byte  = 8'hFF;
    in_valid = 1'b1;
    #1;
    chk("bp_stall", {31'd0, in_ready}, 32'd0);
    tick();
    tick();
    chk("bp_stall2",      {31'd0, in_ready},  32'd0);
    chk("bp_hold_valid",  {31'd0, out_valid}, 32'd1);
    chk("bp_hold_fields", {2'b0, fields},     {2'b0, GOOD});
    out_ready = 1'b1;
    #1;
    chk("bp_release", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_swap_valid",  {31'd0, out_valid}, 32'd1);
    chk("bp_swap_fields", {2'b0, fields},     {2'b0, ALL1F});
    tick();
    chk("bp_drain", {31'd0, out_valid}, 32'd0);

    // Re-align with sync_clr; the byte offered during the clear is dropped
    send_byte(8'hF8);
    send_byte(8'h2A);
    sync_clr = 1'b1;
    in_byte  = 8'h00;
    in_valid = 1'b1;
    tick();
    sync_clr = 1'b0;
    in_valid = 1'b0;
    send_byte(8'hF8);
    send_byte(8'h2A);
    chk("clr_no_word",   {31'd0, out_valid},  32'd0);
    chk("clr_no_err",    {31'd0, marker_err}, 32'd0);
    send_byte(8'hA1);
    chk("clr_no_word2",  {31'd0, out_valid},  32'd0);
    send_byte(8'hC7);
    chk("clr_valid",     {31'd0, out_valid},  32'd1);
    chk("clr_fields",    {2'b0, fields},      {2'b0, GOOD});
    tick();
    chk("clr_one_word",  {31'd0, out_valid},  32'd0);

    // Asynchronous reset in the middle of a word while a word is held
    out_ready = 1'b0;
    send_word(32'hF82AA1C7);
    send_byte(8'hF8);
    send_byte(8'h2A);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_fields",    {2'b0, fields},      32'd0);
    chk("arst_out_valid", {31'd0, out_valid},  32'd0);
    chk("arst_err_cnt",   {24'd0, err_cnt},    32'd0);
    chk("arst_marker",    {31'd0, marker_err}, 32'd0);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    send_byte(8'hFF);
    send_byte(8'hFF);
    chk("arst_restart", {31'd0, out_valid}, 32'd0);
    send_byte(8'hFF);
    send_byte(8'hFF);
    chk("arst_valid",  {31'd0, out_valid}, 32'd1);
    chk("arst_fields2",{2'b0, fields},     {2'b0, ALL1F});
    tick();

`ifdef MARKER_CHECK_EN
    // Saturating error counter
    for (int i = 1; i <= 260; i++) begin
      send_word(32'h00000000);
      chk("sat_out_valid", {31'd0, out_valid},  32'd0);
      chk("sat_marker",    {31'd0, marker_err}, 32'd1);
      chk("sat_err_cnt",   {24'd0, err_cnt},    (i > 255) ? 32'd255 : i);
    end
    tick();
    chk("sat_final", {24'd0, err_cnt}, 32'hFF);
    chk("sat_fields",{2'b0, fields},   {2'b0, ALL1F});
`else
    for (int i = 0; i < 3; i++) begin
      send_word(32'h00000000);
      chk("zero_valid",  {31'd0, out_valid}, 32'd1);
      chk("zero_fields", {2'b0, fields},     32'd0);
      chk("zero_errcnt", {24'd0, err_cnt},   32'd0);
    end
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
